// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - load/store access controller: alignment check, MMU translation, one bus transfer
// Optional build macro MEM_UNMAPPED_KSEG_EN lets kseg0/kseg1 addresses bypass the MMU.
module mem_access_ctrl (
    input  logic        clk,
    input  logic        res,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_vaddr,
    input  logic [31:0] req_wdata,
    input  logic        flush,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_exc,
    output logic [4:0]  resp_excCode,
    output logic [31:0] resp_badVaddr,
    output logic        mmu_addrValid,
    output logic [31:0] mmu_vAddr,
    input  logic [31:0] mmu_pAddr,
    input  logic        mmu_tlbMiss,
    input  logic        mmu_tlbInvalid,
    input  logic        mmu_tlbModified,
    output logic        bus_valid,
    output logic        bus_write,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_byteEn,
    output logic [31:0] bus_wdata,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_XLATE = 2'd1,
        S_BUS   = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [4:0] EXC_MOD  = 5'd1;
    localparam logic [4:0] EXC_TLBL = 5'd2;
    localparam logic [4:0] EXC_TLBS = 5'd3;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    state_t      state_q, state_d;
    logic        write_q, write_d;
    logic [31:0] vaddr_q, vaddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  byte_en_q, byte_en_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic        bus_valid_q, bus_valid_d;
    logic        flush_q, flush_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_exc_q, resp_exc_d;
    logic [4:0]  resp_code_q, resp_code_d;
    logic [31:0] resp_bad_q, resp_bad_d;

    logic        req_misaligned;
    logic        req_kseg;
    logic [3:0]  req_be;

`ifdef MEM_UNMAPPED_KSEG_EN
    assign req_kseg = (req_vaddr[31:30] == 2'b10);
`else
    assign req_kseg = 1'b0;
`endif

    // Reserved size encoding 3 behaves exactly like a word access.
    always_comb begin
        req_misaligned = 1'b0;
        req_be         = 4'b1111;
        case (req_size)
            2'd0: req_be = 4'b0001 << req_vaddr[1:0];
            2'd1: begin
                req_be         = 4'b0011 << {req_vaddr[1], 1'b0};
                req_misaligned = req_vaddr[0];
            end
            default: req_misaligned = (req_vaddr[1:0] != 2'b00);
        endcase
    end

    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        vaddr_d      = vaddr_q;
        wdata_d      = wdata_q;
        byte_en_d    = byte_en_q;
        bus_addr_d   = bus_addr_q;
        bus_valid_d  = bus_valid_q;
        flush_d      = flush_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = 32'd0;
        resp_exc_d   = 1'b0;
        resp_code_d  = 5'd0;
        resp_bad_d   = 32'd0;

        case (state_q)
            S_IDLE: begin
                flush_d = 1'b0;
                if (req_valid) begin
                    write_d   = req_write;
                    vaddr_d   = req_vaddr;
                    wdata_d   = req_wdata;
                    byte_en_d = req_be;
                    if (req_misaligned) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_exc_d   = 1'b1;
                        resp_code_d  = req_write ? EXC_ADES : EXC_ADEL;
                        resp_bad_d   = req_vaddr;
                    end else if (req_kseg) begin
                        state_d     = S_BUS;
                        bus_valid_d = 1'b1;
                        bus_addr_d  = req_vaddr & 32'h1fff_fffc;
                    end else begin
                        state_d = S_XLATE;
                    end
                end
            end
            S_XLATE: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (mmu_tlbMiss || mmu_tlbInvalid) begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_exc_d   = 1'b1;
                    resp_code_d  = write_q ? EXC_TLBS : EXC_TLBL;
                    resp_bad_d   = vaddr_q;
                end else if (write_q && mmu_tlbModified) begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_exc_d   = 1'b1;
                    resp_code_d  = EXC_MOD;
                    resp_bad_d   = vaddr_q;
                end else begin
                    state_d     = S_BUS;
                    bus_valid_d = 1'b1;
                    bus_addr_d  = mmu_pAddr & 32'hffff_fffc;
                end
            end
            S_BUS: begin
                // A flushed transfer still runs to completion; only its response is dropped.
                if (flush) begin
                    flush_d = 1'b1;
                end
                if (bus_ready) begin
                    bus_valid_d = 1'b0;
                    if (flush || flush_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = write_q ? 32'd0 : bus_rdata;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q      <= S_IDLE;
            write_q      <= 1'b0;
            vaddr_q      <= 32'd0;
            wdata_q      <= 32'd0;
            byte_en_q    <= 4'd0;
            bus_addr_q   <= 32'd0;
            bus_valid_q  <= 1'b0;
            flush_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_exc_q   <= 1'b0;
            resp_code_q  <= 5'd0;
            resp_bad_q   <= 32'd0;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            vaddr_q      <= vaddr_d;
            wdata_q      <= wdata_d;
            byte_en_q    <= byte_en_d;
            bus_addr_q   <= bus_addr_d;
            bus_valid_q  <= bus_valid_d;
            flush_q      <= flush_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_exc_q   <= resp_exc_d;
            resp_code_q  <= resp_code_d;
            resp_bad_q   <= resp_bad_d;
        end
    end

    assign req_ready     = (state_q == S_IDLE);
    assign mmu_addrValid = (state_q == S_XLATE);
    assign mmu_vAddr     = (state_q == S_XLATE) ? vaddr_q : 32'd0;

    // A flush arriving in the response cycle cancels the strobe it would otherwise carry.
    assign resp_valid    = resp_valid_q && !flush;
    assign resp_rdata    = resp_rdata_q;
    assign resp_exc      = resp_exc_q;
    assign resp_excCode  = resp_code_q;
    assign resp_badVaddr = resp_bad_q;

    assign bus_valid     = bus_valid_q;
    assign bus_write     = write_q;
    assign bus_addr      = bus_addr_q;
    assign bus_byteEn    = byte_en_q;
    assign bus_wdata     = wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - self-checking bench for mem_access_ctrl
// Build with or without MEM_UNMAPPED_KSEG_EN; expectations follow the macro.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        res;
    logic        req_valid, req_ready, req_write;
    logic [1:0]  req_size;
    logic [31:0] req_vaddr, req_wdata;
    logic        flush;
    logic        resp_valid, resp_exc;
    logic [31:0] resp_rdata, resp_badVaddr;
    logic [4:0]  resp_excCode;
    logic        mmu_addrValid;
    logic [31:0] mmu_vAddr, mmu_pAddr;
    logic        mmu_tlbMiss, mmu_tlbInvalid, mmu_tlbModified;
    logic        bus_valid, bus_write, bus_ready;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_byteEn;

    always #5 clk = ~clk;

    mem_access_ctrl dut (
        .clk(clk), .res(res),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_vaddr(req_vaddr), .req_wdata(req_wdata),
        .flush(flush),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_exc(resp_exc),
        .resp_excCode(resp_excCode), .resp_badVaddr(resp_badVaddr),
        .mmu_addrValid(mmu_addrValid), .mmu_vAddr(mmu_vAddr), .mmu_pAddr(mmu_pAddr),
        .mmu_tlbMiss(mmu_tlbMiss), .mmu_tlbInvalid(mmu_tlbInvalid),
        .mmu_tlbModified(mmu_tlbModified),
        .bus_valid(bus_valid), .bus_write(bus_write), .bus_addr(bus_addr),
        .bus_byteEn(bus_byteEn), .bus_wdata(bus_wdata),
        .bus_ready(bus_ready), .bus_rdata(bus_rdata)
    );

    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic [31:0] va, wd, pa;
        logic        miss, inval, modf;
        int          waits;
        logic [31:0] rd;
    } txn_t;

    typedef struct {
        int          k;
        logic        exc;
        logic [4:0]  code;
        logic [31:0] bad, rdata;
        logic        xl, bus;
        logic [31:0] addr;
        logic [3:0]  be;
    } exp_t;

    typedef struct {
        txn_t t;
        exp_t e;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic txn_t mk_t(input logic wr, input logic [1:0] sz, input logic [31:0] va,
                                  input logic [31:0] wd, input logic [31:0] pa, input logic miss,
                                  input logic inval, input logic modf, input int waits,
                                  input logic [31:0] rd);
        txn_t t;
        t.wr = wr; t.sz = sz; t.va = va; t.wd = wd; t.pa = pa;
        t.miss = miss; t.inval = inval; t.modf = modf; t.waits = waits; t.rd = rd;
        return t;
    endfunction

    function automatic exp_t mk_e(input int k, input logic exc, input logic [4:0] code,
                                  input logic [31:0] bad, input logic [31:0] rdata, input logic xl,
                                  input logic bus, input logic [31:0] addr, input logic [3:0] be);
        exp_t e;
        e.k = k; e.exc = exc; e.code = code; e.bad = bad; e.rdata = rdata;
        e.xl = xl; e.bus = bus; e.addr = addr; e.be = be;
        return e;
    endfunction

    // Reference outcome of one request, derived from access size in bytes and address arithmetic.
    function automatic exp_t model(input txn_t t);
        exp_t e;
        int   nbytes;
        logic kseg;
        e = mk_e(0, 0, 0, 0, 0, 0, 0, 0, 0);
        nbytes = (t.sz == 2'd0) ? 1 : (t.sz == 2'd1) ? 2 : 4;
`ifdef MEM_UNMAPPED_KSEG_EN
        kseg = (t.va >= 32'h8000_0000) && (t.va < 32'hC000_0000);
`else
        kseg = 1'b0;
`endif
        if ((t.va % nbytes) != 0) begin
            e.k = 1; e.exc = 1; e.code = t.wr ? 5'd5 : 5'd4; e.bad = t.va;
            return e;
        end
        e.be = 4'(((1 << nbytes) - 1) << (t.va % 4));
        if (kseg) begin
            e.bus = 1; e.addr = (t.va % 32'h2000_0000) / 4 * 4; e.k = 2 + t.waits;
            e.rdata = t.rd;
            return e;
        end
        e.xl = 1;
        if (t.miss || t.inval) begin
            e.k = 2; e.exc = 1; e.code = t.wr ? 5'd3 : 5'd2; e.bad = t.va;
        end else if (t.wr && t.modf) begin
            e.k = 2; e.exc = 1; e.code = 5'd1; e.bad = t.va;
        end else begin
            e.bus = 1; e.addr = t.pa / 4 * 4; e.k = 3 + t.waits; e.rdata = t.rd;
        end
        return e;
    endfunction

    // Called at a negedge with the controller idle; returns at the negedge it is idle again.
    task automatic run_txn(input txn_t t, output exp_t o, output logic unstable,
                           output logic [31:0] o_wd, output logic o_wr);
        int   bcnt;
        logic done;
        o = mk_e(-1, 0, 0, 0, 0, 0, 0, 0, 0);
        unstable = 0; o_wd = 0; o_wr = 0; bcnt = 0; done = 0;
        mmu_pAddr = t.pa; mmu_tlbMiss = t.miss; mmu_tlbInvalid = t.inval;
        mmu_tlbModified = t.modf; bus_rdata = t.rd; bus_ready = 0;
        req_valid = 1; req_write = t.wr; req_size = t.sz; req_vaddr = t.va; req_wdata = t.wd;
        @(negedge clk);
        req_valid = 0; req_vaddr = $urandom; req_wdata = $urandom; req_write = $urandom_range(0, 1);
        for (int k = 1; k <= 60 && !done; k++) begin
            if (mmu_addrValid) begin
                o.xl = 1;
                if (mmu_vAddr !== t.va) unstable = 1;
            end
            if (resp_valid) begin
                o.k = k; o.exc = resp_exc; o.code = resp_excCode;
                o.bad = resp_badVaddr; o.rdata = resp_rdata;
            end
            if (bus_valid) begin
                if (!o.bus) begin
                    o.bus = 1; o.addr = bus_addr; o.be = bus_byteEn; o_wd = bus_wdata; o_wr = bus_write;
                end else if (bus_addr !== o.addr || bus_byteEn !== o.be ||
                             bus_wdata !== o_wd || bus_write !== o_wr) begin
                    unstable = 1;
                end
                bus_ready = (bcnt == t.waits);
                bcnt++;
            end else begin
                bus_ready = 0;
            end
            if (req_ready) done = 1;
            else @(negedge clk);
        end
        if (!done) chk("txn_timeout", 32'd0, 32'd1);
        bus_ready = 0;
    endtask

    task automatic check_txn(input txn_t t, input exp_t e);
        exp_t        o;
        logic        unstable, o_wr;
        logic [31:0] o_wd;
        run_txn(t, o, unstable, o_wd, o_wr);
        chk("resp_cycle", o.k, e.k);
        chk("resp_exc", 32'(o.exc), 32'(e.exc));
        chk("resp_excCode", 32'(o.code), 32'(e.code));
        chk("resp_badVaddr", o.bad, e.bad);
        if (!t.wr && !e.exc) chk("resp_rdata", o.rdata, e.rdata);
        chk("mmu_used", 32'(o.xl), 32'(e.xl));
        chk("bus_used", 32'(o.bus), 32'(e.bus));
        if (e.bus) begin
            chk("bus_addr", o.addr, e.addr);
            chk("bus_byteEn", 32'(o.be), 32'(e.be));
            chk("bus_write", 32'(o_wr), 32'(t.wr));
            chk("bus_wdata", o_wd, t.wd);
        end
        chk("stable", 32'(unstable), 32'd0);
    endtask

    vec_t tbl[12];

    initial begin
        logic any_resp;
        txn_t t;

        tbl[0]  = '{mk_t(0, 2, 32'h0040_1000, 32'h0, 32'h0002_1000, 0, 0, 0, 0, 32'hDEAD_BEEF),
                    mk_e(3, 0, 0, 0, 32'hDEAD_BEEF, 1, 1, 32'h0002_1000, 4'b1111)};
        tbl[1]  = '{mk_t(1, 1, 32'h0040_0003, 32'h5555_AAAA, 32'h0, 0, 0, 0, 0, 32'h0),
                    mk_e(1, 1, 5, 32'h0040_0003, 0, 0, 0, 0, 0)};
        tbl[2]  = '{mk_t(1, 2, 32'h0040_2000, 32'hCAFE_F00D, 32'h0005_2000, 0, 0, 1, 0, 32'h0),
                    mk_e(2, 1, 1, 32'h0040_2000, 0, 1, 0, 0, 0)};
        tbl[3]  = '{mk_t(0, 2, 32'h0040_2004, 32'h0, 32'h0005_2004, 1, 0, 0, 0, 32'h1),
                    mk_e(2, 1, 2, 32'h0040_2004, 0, 1, 0, 0, 0)};
        tbl[4]  = '{mk_t(1, 2, 32'h0040_2008, 32'h1234_5678, 32'h0005_2008, 1, 0, 0, 0, 32'h0),
                    mk_e(2, 1, 3, 32'h0040_2008, 0, 1, 0, 0, 0)};
        tbl[5]  = '{mk_t(0, 0, 32'h0040_2005, 32'h0, 32'h0005_2005, 0, 1, 0, 0, 32'h0),
                    mk_e(2, 1, 2, 32'h0040_2005, 0, 1, 0, 0, 0)};
`ifdef MEM_UNMAPPED_KSEG_EN
        tbl[6]  = '{mk_t(0, 0, 32'hA000_1002, 32'h0, 32'h1234_5002, 0, 0, 0, 0, 32'h0102_0304),
                    mk_e(2, 0, 0, 0, 32'h0102_0304, 0, 1, 32'h0000_1000, 4'b0100)};
`else
        tbl[6]  = '{mk_t(0, 0, 32'hA000_1002, 32'h0, 32'h1234_5002, 0, 0, 0, 0, 32'h0102_0304),
                    mk_e(3, 0, 0, 0, 32'h0102_0304, 1, 1, 32'h1234_5000, 4'b0100)};
`endif
        tbl[7]  = '{mk_t(0, 2, 32'h0040_0002, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0),
                    mk_e(1, 1, 4, 32'h0040_0002, 0, 0, 0, 0, 0)};
        tbl[8]  = '{mk_t(0, 1, 32'h0040_0006, 32'h0, 32'h0006_6006, 0, 0, 0, 2, 32'h0BAD_F00D),
                    mk_e(5, 0, 0, 0, 32'h0BAD_F00D, 1, 1, 32'h0006_6004, 4'b1100)};
        tbl[9]  = '{mk_t(1, 3, 32'h0040_7008, 32'hA5A5_0F0F, 32'h0007_7008, 0, 0, 0, 1, 32'h0),
                    mk_e(4, 0, 0, 0, 0, 1, 1, 32'h0007_7008, 4'b1111)};
        tbl[10] = '{mk_t(1, 2, 32'h0040_8000, 32'h0, 32'h0008_8000, 0, 1, 1, 0, 32'h0),
                    mk_e(2, 1, 3, 32'h0040_8000, 0, 1, 0, 0, 0)};
        tbl[11] = '{mk_t(1, 0, 32'h0040_9003, 32'h7700_0000, 32'h0009_A003, 0, 0, 0, 0, 32'h0),
                    mk_e(3, 0, 0, 0, 0, 1, 1, 32'h0009_A000, 4'b1000)};

        res = 1; req_valid = 0; req_write = 0; req_size = 0; req_vaddr = 0; req_wdata = 0;
        flush = 0; mmu_pAddr = 0; mmu_tlbMiss = 0; mmu_tlbInvalid = 0; mmu_tlbModified = 0;
        bus_ready = 0; bus_rdata = 0;
        repeat (2) @(negedge clk);
        res = 0;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_bus_valid", 32'(bus_valid), 32'd0);
        chk("rst_mmu_addrValid", 32'(mmu_addrValid), 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_resp_exc", 32'(resp_exc), 32'd0);

        foreach (tbl[i]) check_txn(tbl[i].t, tbl[i].e);

        for (int i = 0; i < 150; i++) begin
            int seg;
            seg = $urandom_range(0, 3);
            t.wr    = $urandom_range(0, 1);
            t.sz    = 2'($urandom_range(0, 3));
            t.va    = {2'(seg), 30'($urandom)};
            if ($urandom_range(0, 2) != 0) t.va[1:0] = 2'b00;
            t.wd    = $urandom;
            t.pa    = $urandom;
            t.miss  = ($urandom_range(0, 7) == 0);
            t.inval = ($urandom_range(0, 7) == 0);
            t.modf  = ($urandom_range(0, 5) == 0);
            t.waits = $urandom_range(0, 3);
            t.rd    = $urandom;
            check_txn(t, model(t));
        end

        // Flush during a stalled bus transfer: transfer completes, response suppressed.
        mmu_pAddr = 32'h0003_3000; mmu_tlbMiss = 0; mmu_tlbInvalid = 0; mmu_tlbModified = 0;
        req_valid = 1; req_write = 1; req_size = 2; req_vaddr = 32'h0040_3000; req_wdata = 32'h1122_3344;
        @(negedge clk);
        req_valid = 0;
        @(negedge clk);
        any_resp = 0;
        for (int k = 2; k <= 7; k++) begin
            chk("flush_bus_valid", 32'(bus_valid), 32'd1);
            chk("flush_bus_addr", bus_addr, 32'h0003_3000);
            chk("flush_bus_wdata", bus_wdata, 32'h1122_3344);
            if (resp_valid) any_resp = 1;
            flush = (k == 3);
            bus_ready = (k == 7);
            @(negedge clk);
        end
        flush = 0; bus_ready = 0;
        chk("flush_req_ready", 32'(req_ready), 32'd1);
        chk("flush_bus_valid_after", 32'(bus_valid), 32'd0);
        if (resp_valid) any_resp = 1;
        @(negedge clk);
        if (resp_valid) any_resp = 1;
        chk("flush_no_resp", 32'(any_resp), 32'd0);

        // Flush during translation: straight back to idle, no bus request.
        req_valid = 1; req_write = 0; req_size = 2; req_vaddr = 32'h0040_4000;
        @(negedge clk);
        req_valid = 0;
        chk("xlate_active", 32'(mmu_addrValid), 32'd1);
        flush = 1;
        @(negedge clk);
        flush = 0;
        chk("xlate_flush_idle", 32'(req_ready), 32'd1);
        chk("xlate_flush_no_bus", 32'(bus_valid), 32'd0);
        chk("xlate_flush_no_resp", 32'(resp_valid), 32'd0);

        // Flush in the response cycle cancels the strobe.
        req_valid = 1; req_write = 0; req_size = 2; req_vaddr = 32'h0040_0001;
        @(negedge clk);
        req_valid = 0;
        flush = 1;
        #1;
        chk("resp_flush_no_resp", 32'(resp_valid), 32'd0);
        @(negedge clk);
        flush = 0;
        chk("resp_flush_idle", 32'(req_ready), 32'd1);

        // Flush alongside a new request in idle does not block acceptance.
        req_valid = 1; flush = 1; req_write = 0; req_size = 2; req_vaddr = 32'h0040_5000;
        @(negedge clk);
        req_valid = 0;
        chk("idle_flush_accepts", 32'(mmu_addrValid), 32'd1);
        chk("idle_flush_vaddr", mmu_vAddr, 32'h0040_5000);
        @(negedge clk);
        flush = 0;
        chk("idle_flush_abort", 32'(req_ready), 32'd1);

        // Reset in the middle of a bus transfer.
        mmu_pAddr = 32'h0004_4000;
        req_valid = 1; req_write = 0; req_size = 2; req_vaddr = 32'h0040_6000;
        @(negedge clk);
        req_valid = 0;
        @(negedge clk);
        chk("rst_mid_bus_active", 32'(bus_valid), 32'd1);
        res = 1;
        @(negedge clk);
        chk("rst_mid_bus_drop", 32'(bus_valid), 32'd0);
        chk("rst_mid_no_resp", 32'(resp_valid), 32'd0);
        res = 0;
        @(negedge clk);
        chk("rst_mid_req_ready", 32'(req_ready), 32'd1);
        chk("rst_mid_no_resp2", 32'(resp_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory access controller between the pipeline's load/store stage and the system bus; it sits directly upstream of `MMU`, drives its translation port and consumes its physical address and TLB flags. For each load/store request it checks alignment, translates the address (or bypasses mapping for kernel unmapped segments), runs one bus transaction and returns data or an exception code to the pipeline. It handles one request at a time and is the only agent driving the MMU translation port.

## Interface
Parameters:
- `RESET_VECTOR_UNUSED` — none; block has no parameters beyond the `Configuration` macro.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock
- `res`  in  1  synchronous active-high reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  controller can accept (high only in IDLE)
- `req_write`  in  1  1 = store, 0 = load
- `req_size`  in  2  0 byte, 1 half, 2 word; 3 reserved, treated as word
- `req_vaddr`  in  32  virtual address
- `req_wdata`  in  32  store data, already lane-aligned
- `flush`  in  1  cancel the in-flight request's response
- `resp_valid`  out  1  one-cycle response strobe
- `resp_rdata`  out  32  raw bus word for loads
- `resp_exc`  out  1  response carries an exception
- `resp_excCode`  out  5  1 Mod, 2 TLBL, 3 TLBS, 4 AdEL, 5 AdES
- `resp_badVaddr`  out  32  faulting virtual address
- `mmu_addrValid`  out  1  translation request to MMU
- `mmu_vAddr`  out  32  virtual address to MMU
- `mmu_pAddr`  in  32  physical address from MMU (valid in the cycle `mmu_addrValid` is high)
- `mmu_tlbMiss`, `mmu_tlbInvalid`, `mmu_tlbModified`  in  1 each  MMU fault flags, same cycle
- `bus_valid`  out  1  bus request
- `bus_write`  out  1  bus direction
- `bus_addr`  out  32  physical address, low 2 bits forced 0
- `bus_byteEn`  out  4  lane enables
- `bus_wdata`  out  32  store data
- `bus_ready`  in  1  bus completes transfer this cycle
- `bus_rdata`  in  32  read data, valid with `bus_ready`

## Operation
- States: IDLE, XLATE, BUS, RESP.
- IDLE: `req_ready`=1. On `req_valid`: capture write, size, vaddr, wdata. Misaligned (half with vaddr[0]=1, word with vaddr[1:0]≠0) → RESP with AdEL (load) / AdES (store). Else unmapped segment (see Configuration) → BUS with `bus_addr` = vaddr & 32'h1fffffff. Else → XLATE.
- XLATE: `mmu_addrValid`=1, `mmu_vAddr`=captured vaddr. Priority: miss or invalid → TLBL/TLBS; store with `mmu_tlbModified` → Mod; else latch `mmu_pAddr` and → BUS. Faults → RESP.
- Byte enables: byte → 4'b0001<<vaddr[1:0]; half → 4'b0011<<{vaddr[1],1'b0}; word → 4'b1111.
- BUS: `bus_valid`=1 with stable addr/write/byteEn/wdata until `bus_ready`; on `bus_ready` capture `bus_rdata` → RESP.
- RESP: `resp_valid`=1 for exactly one cycle (unless flushed); `resp_badVaddr` = captured vaddr when `resp_exc`, else 0. → IDLE.
- `flush`: in XLATE or RESP → IDLE immediately, no response. In BUS the transfer completes (bus must not be abandoned) and the response is suppressed; flush is remembered in a sticky bit cleared on return to IDLE. Flush in IDLE ignored; flush with `req_valid` in IDLE still accepts the request.

## Timing
- Reset: state IDLE; `req_ready`=1 after reset cycle; all other outputs 0, sticky flush 0.
- Reset mid-transaction: `bus_valid` drops the next cycle; no response.
- Mapped, zero-wait bus: accept N, XLATE N+1, BUS N+2 (`bus_ready` same cycle), `resp_valid` N+3.
- Unmapped: accept N, BUS N+1, response N+2. Alignment fault: response N+1.
- Each bus wait cycle adds one cycle. Outputs registered except `req_ready`, `mmu_addrValid`, `mmu_vAddr` (decoded from state).

## Configuration
- `MEM_UNMAPPED_KSEG_EN`: defined → vaddr[31:30]=2'b10 (kseg0/kseg1, 0x80000000–0xBFFFFFFF) bypasses MMU, physical = vaddr & 32'h1fffffff. Undefined → every aligned access goes through XLATE.

## Test plan
- Aligned word load vaddr 0x00401000, MMU pAddr 0x00021000, bus_ready at first BUS cycle → `bus_addr`=0x00021000, byteEn 4'b1111, `resp_valid` 3 cycles after accept, rdata = bus_rdata 0xDEADBEEF.
- Half store vaddr 0x00400003 → no bus activity, next cycle resp_exc=1, excCode=5, badVaddr=0x00400003.
- Store with mmu_tlbModified=1 → excCode=1; load with mmu_tlbMiss=1 → excCode=2; store with miss → 3.
- With `MEM_UNMAPPED_KSEG_EN`, byte load vaddr 0xA0001002 → `mmu_addrValid` never high, bus_addr=0x00001000, byteEn 4'b0100; without macro, same request enters XLATE.
- Bus holds `bus_ready` low 5 cycles, `flush` pulsed in second BUS cycle → signals stable throughout, no `resp_valid`, `req_ready` high the cycle after completion.
- Reset asserted during BUS → next cycle bus_valid=0, resp_valid=0, req_ready=1 after reset deasserts.
